// File: rtl/addr_gen.sv
// Address generator: registered address bus, program counter and address-hold byte,
// with an optional extra cycle that corrects the high byte after a page-crossing add.
module addr_gen #(
    parameter int          AW         = 16,
    parameter int unsigned RST_VEC    = 32'h0000_FFFC,
    parameter int unsigned STACK_PAGE = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    DB,
    input  logic [7:0]    REG,
    input  logic [2:0]    op,
    input  logic          fix_en,
    input  logic          ld_ahl,
    input  logic          ld_pc,
    input  logic          inc_pc,
    output logic [AW-1:0] AB,
    output logic [AW-1:0] PC,
    output logic [7:0]    AHL,
    output logic          busy
);
    localparam int            HW     = AW - 8;
    localparam logic [AW-1:0] RST_AB = AW'(RST_VEC);
    localparam logic [HW-1:0] STK_HI = HW'(STACK_PAGE);
    localparam logic [AW-1:0] PAGE   = AW'(256);

    typedef enum logic [1:0] {IDLE, FIX_UP, FIX_DN} state_t;

    state_t               state, state_next;
    logic [AW-1:0]        ab_next;
    logic [8:0]           idx_sum;
    logic [8:0]           bra_sum;
    logic signed [AW-1:0] bra_ofs;

    function automatic logic [AW-1:0] join_addr(input logic [HW-1:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

    // The 9th bit of each low-byte sum is the page carry.
    assign idx_sum = {1'b0, AHL} + {1'b0, REG};
    assign bra_sum = {1'b0, PC[7:0]} + {1'b0, DB};
    assign bra_ofs = AW'($signed(DB));
    assign busy    = (state != IDLE);

    always_comb begin
        ab_next    = AB;
        state_next = IDLE;
        case (state)
            FIX_UP: ab_next = AB + PAGE;
            FIX_DN: ab_next = AB - PAGE;
            IDLE: begin
                case (op)
                    3'b000: ab_next = AB;
                    3'b001: ab_next = AB + AW'(1);
                    3'b010: ab_next = PC;
                    3'b011: ab_next = join_addr(HW'(DB), AHL);
                    3'b100: begin
                        if (fix_en) begin
                            ab_next = join_addr(HW'(DB), idx_sum[7:0]);
                            if (idx_sum[8]) state_next = FIX_UP;
                        end else begin
                            ab_next = join_addr(HW'(DB), AHL) + AW'(REG);
                        end
                    end
                    3'b101: ab_next = join_addr('0, DB + REG);
                    3'b110: ab_next = join_addr(STK_HI, REG);
                    3'b111: begin
                        if (fix_en) begin
                            // Borrow is signalled by the absence of a carry on negative offsets.
                            ab_next = join_addr(PC[AW-1:8], bra_sum[7:0]);
                            if (!DB[7] && bra_sum[8]) state_next = FIX_UP;
                            if (DB[7] && !bra_sum[8]) state_next = FIX_DN;
                        end else begin
                            ab_next = PC + $unsigned(bra_ofs);
                        end
                    end
                    default: ab_next = AB;
                endcase
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            AB    <= RST_AB;
            PC    <= RST_AB;
            AHL   <= 8'h00;
        end else begin
            state <= state_next;
            AB    <= ab_next;
            if (ld_pc)  PC  <= AB + AW'(inc_pc);
            if (ld_ahl) AHL <= DB;
        end
    end
endmodule

// File: tb/tb_addr_gen.sv
// Bench for addr_gen: directed scenarios plus randomized traffic against an
// integer-arithmetic reference of the address rules.
module tb_addr_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  DB = '0, REG = '0;
    logic [2:0]  op = '0;
    logic        fix_en = 1'b0, ld_ahl = 1'b0, ld_pc = 1'b0, inc_pc = 1'b0;
    logic [15:0] AB, PC;
    logic [7:0]  AHL;
    logic        busy;

    int checks = 0;
    int failures = 0;

    // Reference state: addresses as plain integers; m_fix is the pending page step (+1/-1/0).
    int m_ab, m_pc, m_ahl, m_fix;

    addr_gen #(.AW(16), .RST_VEC(32'h0000_FFFC), .STACK_PAGE(1)) dut (
        .clk(clk), .rst(rst), .DB(DB), .REG(REG), .op(op), .fix_en(fix_en),
        .ld_ahl(ld_ahl), .ld_pc(ld_pc), .inc_pc(inc_pc),
        .AB(AB), .PC(PC), .AHL(AHL), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic int wrap16(input int x);
        return ((x % 65536) + 65536) % 65536;
    endfunction

    task automatic model_reset();
        m_ab = 'hFFFC; m_pc = 'hFFFC; m_ahl = 0; m_fix = 0;
    endtask

    task automatic model_edge();
        int nab, npc, d, r, off, lo;
        d = int'(DB); r = int'(REG);
        nab = m_ab;
        npc = ld_pc ? wrap16(m_ab + int'(inc_pc)) : m_pc;
        if (m_fix != 0) begin
            nab = wrap16(m_ab + 256 * m_fix);
            m_fix = 0;
        end else begin
            case (int'(op))
                0: nab = m_ab;
                1: nab = wrap16(m_ab + 1);
                2: nab = m_pc;
                3: nab = d * 256 + m_ahl;
                4: if (!fix_en) nab = wrap16(d * 256 + m_ahl + r);
                   else begin
                       nab = d * 256 + (m_ahl + r) % 256;
                       if (m_ahl + r > 255) m_fix = 1;
                   end
                5: nab = (d + r) % 256;
                6: nab = 256 + r;
                default: begin
                    off = (d < 128) ? d : d - 256;
                    if (!fix_en) nab = wrap16(m_pc + off);
                    else begin
                        lo = m_pc % 256 + d;
                        nab = (m_pc / 256) * 256 + lo % 256;
                        if (d < 128 && lo > 255) m_fix = 1;
                        if (d >= 128 && lo <= 255) m_fix = -1;
                    end
                end
            endcase
        end
        if (ld_ahl) m_ahl = d;
        m_ab = nab;
        m_pc = npc;
    endtask

    task automatic cycle(input logic [2:0] o, input logic [7:0] d, input logic [7:0] r,
                         input logic fe, input logic lp, input logic ip, input logic la);
        op = o; DB = d; REG = r; fix_en = fe; ld_pc = lp; inc_pc = ip; ld_ahl = la;
        model_edge();
        @(posedge clk); #1;
    endtask

    task automatic set_ab(input logic [15:0] v);
        cycle(3'd0, v[7:0], 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(3'd3, v[15:8], 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_pc(input logic [15:0] v);
        set_ab(v);
        cycle(3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++; if (AB !== 16'hFFFC) begin failures++; $display("FAIL reset_ab got=%h exp=fffc", AB); end
        checks++; if (PC !== 16'hFFFC) begin failures++; $display("FAIL reset_pc got=%h exp=fffc", PC); end
        checks++; if (AHL !== 8'h00) begin failures++; $display("FAIL reset_ahl got=%h exp=00", AHL); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_absx();
        cycle(3'd0, 8'h34, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(3'd4, 8'h12, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h1239) begin failures++; $display("FAIL absx_nocross_ab got=%h exp=1239", AB); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL absx_nocross_busy got=%b exp=0", busy); end
        cycle(3'd0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(3'd4, 8'h12, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h1210 || busy !== 1'b1) begin failures++; $display("FAIL absx_cross_first got=%h/%b exp=1210/1", AB, busy); end
        cycle(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h1310 || busy !== 1'b0) begin failures++; $display("FAIL absx_cross_fix got=%h/%b exp=1310/0", AB, busy); end
        cycle(3'd4, 8'h12, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h1310 || busy !== 1'b0) begin failures++; $display("FAIL absx_full_add got=%h/%b exp=1310/0", AB, busy); end
    endtask

    task automatic test_branch();
        set_pc(16'h1005);
        checks++; if (PC !== 16'h1005) begin failures++; $display("FAIL bra_pc_setup got=%h exp=1005", PC); end
        cycle(3'd7, 8'hF0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h10F5 || busy !== 1'b1) begin failures++; $display("FAIL bra_back_first got=%h/%b exp=10f5/1", AB, busy); end
        cycle(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h0FF5 || busy !== 1'b0) begin failures++; $display("FAIL bra_back_fix got=%h/%b exp=0ff5/0", AB, busy); end
        cycle(3'd7, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h0FF5 || busy !== 1'b0) begin failures++; $display("FAIL bra_back_full got=%h/%b exp=0ff5/0", AB, busy); end
        set_pc(16'h10F0);
        cycle(3'd7, 8'h20, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h1010 || busy !== 1'b1) begin failures++; $display("FAIL bra_fwd_first got=%h/%b exp=1010/1", AB, busy); end
        cycle(3'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h1110 || busy !== 1'b0) begin failures++; $display("FAIL bra_fwd_fix got=%h/%b exp=1110/0", AB, busy); end
    endtask

    task automatic test_wrap();
        cycle(3'd5, 8'hF0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h0010 || busy !== 1'b0) begin failures++; $display("FAIL zpx_wrap got=%h/%b exp=0010/0", AB, busy); end
        set_ab(16'hFFFF);
        cycle(3'd1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h0000) begin failures++; $display("FAIL inc_wrap got=%h exp=0000", AB); end
        set_ab(16'hFFFF);
        cycle(3'd0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        checks++; if (PC !== 16'h0000) begin failures++; $display("FAIL pc_wrap got=%h exp=0000", PC); end
        set_pc(16'h1234);
        set_ab(16'h5678);
        cycle(3'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (AB !== 16'h1234) begin failures++; $display("FAIL pcr_old_pc got=%h exp=1234", AB); end
        checks++; if (PC !== 16'h5678) begin failures++; $display("FAIL pcr_ld_pc got=%h exp=5678", PC); end
    endtask

    task automatic test_busy_op();
        cycle(3'd0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(3'd4, 8'h12, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_enter got=%b exp=1", busy); end
        cycle(3'd6, 8'h00, 8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++; if (AB !== 16'h1310 || busy !== 1'b0) begin failures++; $display("FAIL busy_stk_ignored got=%h/%b exp=1310/0", AB, busy); end
        checks++; if (PC !== 16'h1210) begin failures++; $display("FAIL busy_ld_pc got=%h exp=1210", PC); end
        cycle(3'd6, 8'h00, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'h0142) begin failures++; $display("FAIL stk_after_busy got=%h exp=0142", AB); end
    endtask

    task automatic test_reset_while_busy();
        cycle(3'd0, 8'hF0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(3'd4, 8'h12, 8'h20, 1'b1, 1'b1, 1'b1, 1'b0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (AB !== 16'hFFFC || PC !== 16'hFFFC) begin failures++; $display("FAIL async_reset_ab_pc got=%h/%h exp=fffc/fffc", AB, PC); end
        checks++; if (AHL !== 8'h00 || busy !== 1'b0) begin failures++; $display("FAIL async_reset_ahl_busy got=%h/%b exp=00/0", AHL, busy); end
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(3'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (AB !== 16'hFFFD || busy !== 1'b0) begin failures++; $display("FAIL post_reset_inc got=%h/%b exp=fffd/0", AB, busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'($urandom),
                  1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom_range(0, 2) == 0));
            checks++; if (int'(AB) !== m_ab) begin failures++; $display("FAIL rand_ab i=%0d got=%h exp=%h", i, AB, m_ab); end
            checks++; if (int'(PC) !== m_pc) begin failures++; $display("FAIL rand_pc i=%0d got=%h exp=%h", i, PC, m_pc); end
            checks++; if (int'(AHL) !== m_ahl) begin failures++; $display("FAIL rand_ahl i=%0d got=%h exp=%h", i, AHL, m_ahl); end
            checks++; if (busy !== (m_fix != 0)) begin failures++; $display("FAIL rand_busy i=%0d got=%b exp=%b", i, busy, m_fix != 0); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_absx();
        test_branch();
        test_wrap();
        test_busy_op();
        test_reset_while_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/addr_gen.md
ADDR_GEN -- requirements
Module: addr_gen

Interface
REQ-001 SHALL provide parameter: AW, 16, address width in bits; legal range 9..24.
REQ-002 SHALL provide parameter: RST_VEC, 16'hFFFC, AB and PC value at reset, truncated to AW bits.
REQ-003 SHALL provide parameter: STACK_PAGE, 1, upper address bits used by the STK op.
REQ-004 SHALL provide ports: clk  in  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL provide ports: rst  in  1  reset, asynchronous and active-high.
REQ-006 SHALL provide ports: DB  in  8  data bus input.
REQ-007 SHALL provide ports: REG  in  8  register file output (index or stack pointer).
REQ-008 SHALL provide ports: op  in  3  address operation select.
REQ-009 SHALL provide ports: fix_en  in  1  1 = split page-crossing adds across two cycles; 0 = full-width add in one cycle.
REQ-010 SHALL provide ports: ld_ahl  in  1  load AHL from DB.
REQ-011 SHALL provide ports: ld_pc  in  1  load PC.
REQ-012 SHALL provide ports: inc_pc  in  1  increment applied when PC is loaded.
REQ-013 SHALL provide ports: AB  out  AW  registered address bus.
REQ-014 SHALL provide ports: PC  out  AW  program counter.
REQ-015 SHALL provide ports: AHL  out  8  address hold low byte.
REQ-016 SHALL provide ports: busy  out  1  high while the block is in a fix-up state; op is ignored while busy is high.

Function
REQ-017 SHALL compute AB_next combinationally and register it into AB on each clk edge; all AB arithmetic wraps modulo 2^AW.
REQ-018 SHALL implement op 000 HOLD: AB_next = AB.
REQ-019 SHALL implement op 001 INC: AB_next = AB + 1.
REQ-020 SHALL implement op 010 PCR: AB_next = PC.
REQ-021 SHALL implement op 011 ABS: AB_next = {DB zero-extended/truncated to AW-8 bits, AHL}.
REQ-022 SHALL implement op 100 ABSX: with fix_en=0, AB_next = {DB, AHL} + REG; with fix_en=1, AB_next = {DB, (AHL+REG) mod 256}, entering FIX_UP if AHL+REG > 255.
REQ-023 SHALL implement op 101 ZPX: AB_next = {0, (DB+REG) mod 256}, with no page crossing ever.
REQ-024 SHALL implement op 110 STK: AB_next = {STACK_PAGE, REG}.
REQ-025 SHALL implement op 111 BRA with DB as a signed 8-bit offset.
REQ-026 SHALL compute BRA with fix_en=0 as AB_next = PC + sign-extended DB.
REQ-027 SHALL compute BRA with fix_en=1 as AB_next = {PC[AW-1:8], (PC[7:0]+DB) mod 256}; enter FIX_UP if DB[7]=0 and the low add carries; enter FIX_DN if DB[7]=1 and the low add does not carry.
REQ-028 SHALL implement the state machine: IDLE -> FIX_UP or FIX_DN per REQ-022/REQ-027; FIX_UP: AB_next = AB + 256, then IDLE; FIX_DN: AB_next = AB - 256, then IDLE; each fix state lasts exactly one cycle.
REQ-029 SHALL drive busy = 1 exactly while the state is FIX_UP or FIX_DN; busy is a decode of registered state.
REQ-030 SHALL update PC on every clk edge with ld_pc=1 as PC <= AB + inc_pc (current registered AB, AW-bit wrap), in any state, including while busy.
REQ-031 SHALL update AHL <= DB on every clk edge with ld_ahl=1, in any state.
REQ-032 SHALL treat simultaneous ld_pc and op=PCR as PCR reading the old PC.

Reset
REQ-033 SHALL, while rst=1, immediately force AB=RST_VEC, PC=RST_VEC, AHL=8'h00, state=IDLE and busy=0, independent of clk, including while in a fix-up state.
REQ-034 SHALL resume normal operation on the first clk edge after rst falls, with op evaluated from IDLE.

Verification (AW=16, defaults)
REQ-035 SHALL cover reset: assert rst while busy=1 -> AB=0xFFFC, PC=0xFFFC, AHL=0x00, busy=0 without a clk edge.
REQ-036 SHALL cover ABSX without crossing: AHL=0x34, DB=0x12, REG=0x05, fix_en=1 -> AB=0x1239, busy=0.
REQ-037 SHALL cover ABSX with crossing: AHL=0xF0, DB=0x12, REG=0x20, fix_en=1 -> AB=0x1210 with busy=1, next cycle AB=0x1310 with busy=0; same stimulus with fix_en=0 -> AB=0x1310 in one cycle.
REQ-038 SHALL cover backward branch crossing: PC=0x1005, DB=0xF0, fix_en=1 -> AB=0x10F5 with busy=1, then AB=0x0FF5; forward branch PC=0x10F0, DB=0x20 -> AB=0x1010, then AB=0x1110.
REQ-039 SHALL cover wrap: ZPX DB=0xF0, REG=0x20 -> AB=0x0010; AB=0xFFFF with INC -> AB=0x0000; AB=0xFFFF with ld_pc=1, inc_pc=1 -> PC=0x0000.
REQ-040 SHALL cover op during busy: an ABSX cross followed by op=STK on the busy cycle -> STK ignored, fix-up completes, and STK is accepted on the following cycle -> AB=0x01xx with xx=REG.
